mmio_data_fifo: RTL and testbench

Buffering stage directly downstream of the AFU's MMIO write decode. Each host MMIO write to the user register pushes one 64-bit word into this FIFO. Each MMIO read of that register pops the oldest word, which the AFU returns on its read-response path. The block is first-word-fall-through and reports occupancy and sticky overflow/underflow status for a host-visible status CSR.

---
 rtl/mmio_fifo_pkg.sv | 27 ++
 rtl/mmio_fifo_mem.sv | 39 +++
 rtl/mmio_data_fifo.sv | 112 +++++++++++
 tb/tb_mmio_data_fifo.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_fifo_pkg.sv
// ---------------------------------------------------------------------------
// mmio_fifo_pkg
// Shared constants and types for the MMIO user-register data FIFO.
//   - Default FIFO geometry (width/depth) and the derived count width.
//   - MMIO addresses of the user data register and the FIFO status CSR.
//   - t_fifo_status: the packed layout of the host-visible status CSR.
// ---------------------------------------------------------------------------
package mmio_fifo_pkg;

   localparam int MMIO_FIFO_WIDTH = 64;
   localparam int MMIO_FIFO_DEPTH = 8;
   localparam int MMIO_FIFO_CW    = $clog2(MMIO_FIFO_DEPTH) + 1;

   // Host MMIO map: writes to the user register push, reads pop.
   localparam logic [15:0] MMIO_FIFO_USER_ADDR   = 16'h0020;
   localparam logic [15:0] MMIO_FIFO_STATUS_ADDR = 16'h0022;

   // Status CSR, MSB first: {overflow, underflow, full, empty, count}.
   typedef struct packed {
      logic                    overflow;
      logic                    underflow;
      logic                    full;
      logic                    empty;
      logic [MMIO_FIFO_CW-1:0] count;
   } t_fifo_status;

endpackage : mmio_fifo_pkg

// File: rtl/mmio_fifo_mem.sv
// ---------------------------------------------------------------------------
// mmio_fifo_mem
// DEPTH x WIDTH register array backing the MMIO data FIFO.
// Ports:
//   clk    in   write clock
//   we     in   write enable
//   waddr  in   write address (sampled on rising edge with we)
//   wdata  in   write data
//   raddr  in   asynchronous read address
//   rdata  out  mem[raddr], combinational
// ---------------------------------------------------------------------------
module mmio_fifo_mem
   import mmio_fifo_pkg::*;
#(
   parameter int WIDTH = MMIO_FIFO_WIDTH,
   parameter int DEPTH = MMIO_FIFO_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // NOTE: the array has no reset; the controller never exposes an entry
   // that has not been written since reset, so clearing it buys nothing.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule : mmio_fifo_mem

// File: rtl/mmio_data_fifo.sv
// ---------------------------------------------------------------------------
// mmio_data_fifo
// First-word-fall-through FIFO between the AFU MMIO write decode and its
// read-response path. Host writes push, host reads pop; occupancy and
// sticky error flags feed the status CSR.
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   push_en    in   push one word this cycle
//   push_data  in   word to push
//   pop_en     in   pop the head word this cycle
//   pop_data   out  head word (0 while empty)
//   empty      out  count == 0
//   full       out  count == DEPTH
//   count      out  occupancy, 0..DEPTH
//   overflow   out  sticky: a push was dropped
//   underflow  out  sticky: a pop arrived while empty
//   clr_err    in   synchronous clear of both sticky flags
// ---------------------------------------------------------------------------
module mmio_data_fifo
   import mmio_fifo_pkg::*;
#(
   parameter int WIDTH = MMIO_FIFO_WIDTH,
   parameter int DEPTH = MMIO_FIFO_DEPTH,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_en,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop_en,
   output logic [WIDTH-1:0] pop_data,
   output logic             empty,
   output logic             full,
   output logic [CW-1:0]    count,
   output logic             overflow,
   output logic             underflow,
   input  logic             clr_err
);

   localparam int AW = $clog2(DEPTH);

   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [WIDTH-1:0] head_data;
   logic             push_ok;
   logic             pop_ok;
   logic             ovf_evt;
   logic             unf_evt;

   // Full/empty come from the count so a full FIFO and an empty one are
   // never confused when the pointers are equal.
   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));

   // A push at full is still accepted when a pop frees the head slot in the
   // same cycle. A pop while empty is ignored even if a push arrives, since
   // data never bypasses storage.
   assign push_ok = push_en & (~full | pop_en);
   assign pop_ok  = pop_en & ~empty;
   assign ovf_evt = push_en & ~push_ok;
   assign unf_evt = pop_en & empty;

   mmio_fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .we    (push_ok),
      .waddr (wr_ptr),
      .wdata (push_data),
      .raddr (rd_ptr),
      .rdata (head_data)
   );

   // Stale array contents are masked while empty.
   assign pop_data = empty ? '0 : head_data;

   // NOTE: all state below uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + CW'(push_ok) - CW'(pop_ok);

         // A new error event wins over a simultaneous clear.
         if (ovf_evt) begin
            overflow <= 1'b1;
         end else if (clr_err) begin
            overflow <= 1'b0;
         end
         if (unf_evt) begin
            underflow <= 1'b1;
         end else if (clr_err) begin
            underflow <= 1'b0;
         end
      end
   end

endmodule : mmio_data_fifo

// File: tb/tb_mmio_data_fifo.sv
// ---------------------------------------------------------------------------
// tb_mmio_data_fifo
// Directed self-checking bench for mmio_data_fifo (WIDTH=64, DEPTH=8).
// Inputs change 1 ns after each rising edge; outputs are checked there too.
// ---------------------------------------------------------------------------
module tb_mmio_data_fifo;

   localparam int WIDTH = 64;
   localparam int DEPTH = 8;
   localparam int CW    = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             push_en;
   logic [WIDTH-1:0] push_data;
   logic             pop_en;
   logic [WIDTH-1:0] pop_data;
   logic             empty;
   logic             full;
   logic [CW-1:0]    count;
   logic             overflow;
   logic             underflow;
   logic             clr_err;

   int n_checks = 0;
   int n_errors = 0;

   logic [WIDTH-1:0] model_q [$];

   mmio_data_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .push_en   (push_en),
      .push_data (push_data),
      .pop_en    (pop_en),
      .pop_data  (pop_data),
      .empty     (empty),
      .full      (full),
      .count     (count),
      .overflow  (overflow),
      .underflow (underflow),
      .clr_err   (clr_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      push_en   = 1'b0;
      pop_en    = 1'b0;
      clr_err   = 1'b0;
      push_data = '0;
   endtask

   task automatic fill_1_to_8();
      for (int i = 1; i <= 8; i++) begin
         push_en   = 1'b1;
         push_data = 64'(i);
         tick();
      end
      idle();
   endtask

   // Pops n words, checking the head before each popping edge.
   task automatic drain(input string tag, input logic [63:0] first, input int n);
      for (int i = 0; i < n; i++) begin
         check(tag, pop_data, first + 64'(i));
         pop_en = 1'b1;
         tick();
         pop_en = 1'b0;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      idle();

      // ---- reset values, before any clock edge ----
      #3;
      check("rst_empty", 64'(empty), 64'd1);
      check("rst_full", 64'(full), 64'd0);
      check("rst_count", 64'(count), 64'd0);
      check("rst_ovf", 64'(overflow), 64'd0);
      check("rst_unf", 64'(underflow), 64'd0);
      check("rst_pop_data", pop_data, 64'd0);
      tick();
      tick();
      rst_n = 1'b1;

      // ---- idle after release ----
      repeat (5) tick();
      check("idle_empty", 64'(empty), 64'd1);
      check("idle_count", 64'(count), 64'd0);
      check("idle_pop_data", pop_data, 64'd0);

      // ---- fill, drain, ordering ----
      push_en   = 1'b1;
      push_data = 64'h1;
      tick();
      check("push_lat_empty", 64'(empty), 64'd0);
      check("push_lat_data", pop_data, 64'h1);
      for (int i = 2; i <= 8; i++) begin
         push_data = 64'(i);
         tick();
      end
      idle();
      check("fill_full", 64'(full), 64'd1);
      check("fill_count", 64'(count), 64'd8);
      drain("drain1", 64'h1, 8);
      check("drain1_empty", 64'(empty), 64'd1);
      check("drain1_count", 64'(count), 64'd0);
      check("drain1_pop_data", pop_data, 64'd0);
      check("drain1_unf", 64'(underflow), 64'd0);

      // ---- overflow ----
      fill_1_to_8();
      push_en   = 1'b1;
      push_data = 64'hDEAD;
      tick();
      idle();
      check("ovf_flag", 64'(overflow), 64'd1);
      check("ovf_count", 64'(count), 64'd8);
      check("ovf_full", 64'(full), 64'd1);
      drain("ovf_drain", 64'h1, 8);
      check("ovf_sticky", 64'(overflow), 64'd1);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      check("ovf_clr", 64'(overflow), 64'd0);

      // ---- simultaneous push and pop at full ----
      fill_1_to_8();
      push_en   = 1'b1;
      push_data = 64'h9;
      pop_en    = 1'b1;
      tick();
      idle();
      check("pp_count", 64'(count), 64'd8);
      check("pp_full", 64'(full), 64'd1);
      check("pp_ovf", 64'(overflow), 64'd0);
      drain("pp_drain", 64'h2, 8);
      check("pp_empty", 64'(empty), 64'd1);

      // ---- underflow with push ----
      pop_en    = 1'b1;
      push_en   = 1'b1;
      push_data = 64'hA5;
      tick();
      idle();
      check("unf_flag", 64'(underflow), 64'd1);
      check("unf_count", 64'(count), 64'd1);
      check("unf_pop_data", pop_data, 64'hA5);
      pop_en = 1'b1;
      tick();
      pop_en = 1'b0;
      check("unf_pop_empty", 64'(empty), 64'd1);
      clr_err = 1'b1;
      pop_en  = 1'b1;
      tick();
      idle();
      check("unf_set_wins", 64'(underflow), 64'd1);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      check("unf_clr", 64'(underflow), 64'd0);

      // ---- wrap: 20 pushes, popping every cycle from the third ----
      model_q.delete();
      for (int i = 0; i < 20; i++) begin
         push_en   = 1'b1;
         push_data = 64'h100 + 64'(i);
         pop_en    = (i >= 2);
         if (pop_en) begin
            check("wrap_data", pop_data, model_q[0]);
            void'(model_q.pop_front());
         end
         model_q.push_back(push_data);
         tick();
      end
      idle();
      check("wrap_count", 64'(count), 64'd2);
      drain("wrap_tail", 64'h112, 2);
      check("wrap_flags", {62'd0, overflow, underflow}, 64'd0);

      // ---- asynchronous reset mid-stream ----
      push_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         push_data = 64'h200 + 64'(i);
         tick();
      end
      idle();
      check("prerst_count", 64'(count), 64'd3);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_empty", 64'(empty), 64'd1);
      check("arst_count", 64'(count), 64'd0);
      check("arst_pop_data", pop_data, 64'd0);
      #1;
      rst_n = 1'b1;
      push_en   = 1'b1;
      push_data = 64'h77;
      tick();
      idle();
      check("post_rst_data", pop_data, 64'h77);
      check("post_rst_count", 64'(count), 64'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_mmio_data_fifo
